param_up_down_counter: RTL and testbench

PARAM_UP_DOWN_COUNTER -- requirements
Module: param_up_down_counter

---
 rtl/param_up_down_counter_pkg.sv | 16 +
 rtl/param_up_down_counter_hex.sv | 11 +
 rtl/param_up_down_counter.sv | 97 +++++++++
 tb/tb_param_up_down_counter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/param_up_down_counter_pkg.sv
// Shared glyph constants and hex font for the up/down counter display.
package param_up_down_counter_pkg;

    localparam logic [6:0] SEG_UP    = 7'b0111110;
    localparam logic [6:0] SEG_DOWN  = 7'b1011110;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Active-high, bit6=a .. bit0=g; the leftmost entry is digit F.
    localparam logic [15:0][6:0] HEX_FONT = {
        7'b1000111, 7'b1001111, 7'b0111101, 7'b1001110,
        7'b0011111, 7'b1110111, 7'b1111011, 7'b1111111,
        7'b1110000, 7'b1011111, 7'b1011011, 7'b0110011,
        7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110
    };

endpackage

// File: rtl/param_up_down_counter_hex.sv
// Combinational 4-bit to 7-segment hex glyph lookup.
module seg7_hex_decoder
    import param_up_down_counter_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_FONT[digit_i];

endmodule

// File: rtl/param_up_down_counter.sv
// Parameterised up/down counter with load, wrap/saturate, terminal-count pulse,
// sticky overflow flag and 7-segment direction/hex glyphs.
module param_up_down_counter
    import param_up_down_counter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = 2**WIDTH - 1,
    parameter int SATURATE  = 0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             ovf,
    output logic [6:0]       dir_seg,
    output logic [6:0]       hex_seg,
    output logic             dp
);

    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
        $error("param_up_down_counter: WIDTH %0d outside 2..16", WIDTH);
    end
    if (MAX_COUNT < 1 || MAX_COUNT > 2**WIDTH - 1) begin : g_bad_max
        $error("param_up_down_counter: MAX_COUNT %0d outside 1..%0d", MAX_COUNT, 2**WIDTH - 1);
    end

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic [6:0]       dir_q, dir_d;
    logic [3:0]       digit;

    always_comb begin
        cnt_d = cnt_q;
        tc_d  = 1'b0;
        ovf_d = ovf_q;
        dir_d = dir_q;
        if (load) begin
            cnt_d = (load_val > MAX_V) ? MAX_V : load_val;
        end else if (en) begin
            dir_d = up_down ? SEG_UP : SEG_DOWN;
            if (up_down) begin
                if (cnt_q == MAX_V) begin
                    tc_d  = 1'b1;
                    ovf_d = 1'b1;
                    cnt_d = (SATURATE != 0) ? cnt_q : '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end else begin
                if (cnt_q == '0) begin
                    tc_d  = 1'b1;
                    ovf_d = 1'b1;
                    cnt_d = (SATURATE != 0) ? cnt_q : MAX_V;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_q <= '0;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
            dir_q <= SEG_BLANK;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
            dir_q <= dir_d;
        end
    end

    // Zero-extends narrow counters and keeps the low nibble of wide ones.
    assign digit = 4'(cnt_q);

    seg7_hex_decoder u_hex (
        .digit_i (digit),
        .seg_o   (hex_seg)
    );

    assign out     = cnt_q;
    assign tc      = tc_q;
    assign ovf     = ovf_q;
    assign dir_seg = dir_q;
    assign dp      = 1'b1;

endmodule

// File: tb/tb_param_up_down_counter.sv
// Self-checking bench: two counter configurations driven in parallel and
// compared against an arithmetic reference model plus directed vectors.
module tb_param_up_down_counter;

    logic       clk, clr, en, up_down, load;
    logic [3:0] load_val;

    logic [3:0] a_out, b_out;
    logic       a_tc, a_ovf, a_dp, b_tc, b_ovf, b_dp;
    logic [6:0] a_dir, a_hex, b_dir, b_hex;

    int n_checks = 0;
    int n_errors = 0;

    // Wrapping counter at full range.
    param_up_down_counter #(.WIDTH(4), .SATURATE(0)) dut_a (
        .clk(clk), .clr(clr), .en(en), .up_down(up_down), .load(load),
        .load_val(load_val), .out(a_out), .tc(a_tc), .ovf(a_ovf),
        .dir_seg(a_dir), .hex_seg(a_hex), .dp(a_dp)
    );

    // Saturating decade counter.
    param_up_down_counter #(.WIDTH(4), .MAX_COUNT(9), .SATURATE(1)) dut_b (
        .clk(clk), .clr(clr), .en(en), .up_down(up_down), .load(load),
        .load_val(load_val), .out(b_out), .tc(b_tc), .ovf(b_ovf),
        .dir_seg(b_dir), .hex_seg(b_hex), .dp(b_dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] font [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    typedef struct {
        int         cnt;
        bit         tc;
        bit         ovf;
        logic [6:0] dir;
    } mstate_t;

    mstate_t ma, mb;

    function automatic mstate_t model_reset();
        mstate_t s;
        s.cnt = 0;
        s.tc  = 1'b0;
        s.ovf = 1'b0;
        s.dir = 7'b0000000;
        return s;
    endfunction

    // Counting is modular arithmetic over 0..maxc; leaving that range is a boundary event.
    function automatic mstate_t model_next(mstate_t s, int maxc, bit sat,
                                           bit ld, bit e, bit ud, int lv);
        mstate_t n = s;
        int raw;
        n.tc = 1'b0;
        if (ld) begin
            n.cnt = (lv > maxc) ? maxc : lv;
        end else if (e) begin
            n.dir = ud ? 7'b0111110 : 7'b1011110;
            raw   = s.cnt + (ud ? 1 : -1);
            if (raw < 0 || raw > maxc) begin
                n.tc  = 1'b1;
                n.ovf = 1'b1;
                n.cnt = sat ? s.cnt : (raw + maxc + 1) % (maxc + 1);
            end else begin
                n.cnt = raw;
            end
        end
        return n;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("a_out", int'(a_out), ma.cnt);
        chk("a_tc",  int'(a_tc),  int'(ma.tc));
        chk("a_ovf", int'(a_ovf), int'(ma.ovf));
        chk("a_dir", int'(a_dir), int'(ma.dir));
        chk("a_hex", int'(a_hex), int'(font[ma.cnt % 16]));
        chk("b_out", int'(b_out), mb.cnt);
        chk("b_tc",  int'(b_tc),  int'(mb.tc));
        chk("b_ovf", int'(b_ovf), int'(mb.ovf));
        chk("b_dir", int'(b_dir), int'(mb.dir));
        chk("b_hex", int'(b_hex), int'(font[mb.cnt % 16]));
    endtask

    // Inputs are already stable here; advance one rising edge and check.
    task automatic step();
        ma = model_next(ma, 15, 1'b0, load, en, up_down, int'(load_val));
        mb = model_next(mb, 9,  1'b1, load, en, up_down, int'(load_val));
        @(posedge clk);
        #1;
        compare_all();
    endtask

    // Asynchronous clear pulse placed between edges; checked before the next edge.
    task automatic pulse_clr();
        #2 clr = 1'b1;
        #1;
        ma = model_reset();
        mb = model_reset();
        compare_all();
        #1 clr = 1'b0;
    endtask

    typedef struct {
        bit         ld;
        bit         e;
        bit         ud;
        logic [3:0] lv;
        int         eout;
        bit         etc;
        logic [6:0] edir;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 4'd2,  2, 1'b0, 7'b0000000};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 4'd0,  1, 1'b0, 7'b1011110};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 4'd0,  0, 1'b0, 7'b1011110};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 4'd0,  0, 1'b1, 7'b1011110};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 4'd0,  0, 1'b1, 7'b1011110};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 4'd12, 9, 1'b0, 7'b1011110};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 4'd0,  9, 1'b1, 7'b0111110};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 4'd0,  9, 1'b0, 7'b0111110};

        clr = 1'b1; en = 1'b0; up_down = 1'b0; load = 1'b0; load_val = 4'd0;
        ma = model_reset();
        mb = model_reset();

        // Reset state while clr is held across an edge.
        @(posedge clk);
        #1;
        chk("rst_out", int'(a_out), 0);
        chk("rst_tc",  int'(a_tc),  0);
        chk("rst_ovf", int'(a_ovf), 0);
        chk("rst_dir", int'(a_dir), 0);
        chk("rst_hex", int'(a_hex), int'(7'b1111110));
        chk("rst_dp",  int'(a_dp),  1);
        chk("rst_dp_b", int'(b_dp), 1);
        clr = 1'b0;

        // Full-range count up through the wrap.
        en = 1'b1; up_down = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            step();
            chk("wrap_out", int'(a_out), (k == 16) ? 0 : (k == 17) ? 1 : k);
            chk("wrap_tc",  int'(a_tc),  (k == 16) ? 1 : 0);
            chk("wrap_ovf", int'(a_ovf), (k >= 16) ? 1 : 0);
        end
        for (int k = 0; k < 4; k++) step();
        chk("pre_clr_out", int'(a_out), 5);

        pulse_clr();
        chk("clr_out", int'(a_out), 0);
        chk("clr_ovf", int'(a_ovf), 0);
        chk("clr_dir", int'(a_dir), 0);
        chk("clr_hex", int'(a_hex), int'(7'b1111110));
        step();
        chk("post_clr_out", int'(a_out), 1);

        // Hold with enable low.
        load = 1'b1; load_val = 4'd7; en = 1'b0;
        step();
        load = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("hold_out", int'(a_out), 7);
            chk("hold_tc",  int'(a_tc),  0);
            chk("hold_hex", int'(a_hex), int'(7'b1110000));
        end

        // Saturating decade counter vectors.
        pulse_clr();
        foreach (vecs[i]) begin
            load = vecs[i].ld; en = vecs[i].e; up_down = vecs[i].ud; load_val = vecs[i].lv;
            step();
            chk("vec_out", int'(b_out), vecs[i].eout);
            chk("vec_tc",  int'(b_tc),  int'(vecs[i].etc));
            chk("vec_dir", int'(b_dir), int'(vecs[i].edir));
        end

        // Randomised traffic with occasional asynchronous clears.
        for (int k = 0; k < 400; k++) begin
            load     = ($urandom_range(0, 9) == 0);
            en       = ($urandom_range(0, 9) < 7);
            up_down  = 1'($urandom);
            load_val = 4'($urandom);
            if ($urandom_range(0, 99) == 0) pulse_clr();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
